// File: rtl/hazard_controller.sv
// Load-use stall, branch squash and memory-wait freeze sequencing for the 5-stage pipeline.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller #(
  parameter int LOAD_LATENCY = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  IFID_RS1,
  input  logic [4:0]  IFID_RS2,
  input  logic        IFID_UseRS2,
  input  logic [4:0]  IDEXE_RD,
  input  logic        IDEXE_MemRead,
  input  logic        Branch_Taken,
  input  logic        DMem_Req,
  input  logic        DMem_Ready,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEXE_Flush,
  output logic        Pipe_Freeze,
  output logic        Mem_Err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] Stall_Cycles,
  output logic [31:0] Flush_Count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [2:0]       STALL_INIT = 3'(LOAD_LATENCY - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT   = CNT_W'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           r_saved;
  logic [2:0]       r_stall_cnt;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_mem_err;

  logic w_hazard;
  logic w_memwait;
  logic w_br_flush;

  assign w_hazard  = IDEXE_MemRead && (IDEXE_RD != 5'd0) &&
                     ((IDEXE_RD == IFID_RS1) || (IFID_UseRS2 && (IDEXE_RD == IFID_RS2)));
  assign w_memwait = DMem_Req && !DMem_Ready;

  // Mealy outputs; reset forces a flushed, non-advancing pipeline.
  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEXE_Flush = 1'b0;
    Pipe_Freeze = 1'b0;
    w_br_flush  = 1'b0;
    if (!rst_i) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEXE_Flush = 1'b1;
    end else begin
      case (r_state)
        ST_RUN, ST_LOAD_STALL: begin
          if (w_memwait) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            Pipe_Freeze = 1'b1;
          end else if (Branch_Taken) begin
            IFID_Flush  = 1'b1;
            IDEXE_Flush = 1'b1;
            w_br_flush  = 1'b1;
          end else if (w_hazard || (r_state == ST_LOAD_STALL)) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEXE_Flush = 1'b1;
          end
        end
        default: begin
          PCWrite     = 1'b0;
          IFID_Write  = 1'b0;
          Pipe_Freeze = 1'b1;
        end
      endcase
    end
  end

  assign Mem_Err = rst_i && r_mem_err;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= ST_RUN;
      r_saved     <= ST_RUN;
      r_stall_cnt <= 3'd0;
      r_to_cnt    <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_memwait) begin
            r_saved  <= ST_RUN;
            r_to_cnt <= CNT_W'(1);
            r_state  <= ST_MEM_WAIT;
          end else if (!Branch_Taken && w_hazard && (LOAD_LATENCY > 1)) begin
            r_stall_cnt <= STALL_INIT;
            r_state     <= ST_LOAD_STALL;
          end
        end
        ST_LOAD_STALL: begin
          if (w_memwait) begin
            r_saved  <= ST_LOAD_STALL;
            r_to_cnt <= CNT_W'(1);
            r_state  <= ST_MEM_WAIT;
          end else if (Branch_Taken) begin
            // The branch is older than the stalled load consumer, so drop the stall.
            r_stall_cnt <= 3'd0;
            r_state     <= ST_RUN;
          end else if (r_stall_cnt <= 3'd1) begin
            r_stall_cnt <= 3'd0;
            r_state     <= ST_RUN;
          end else begin
            r_stall_cnt <= r_stall_cnt - 3'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (DMem_Ready) begin
            r_state <= r_saved;
          end else if (r_to_cnt >= TO_LIMIT) begin
            r_mem_err <= 1'b1;
            r_state   <= r_saved;
          end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      Stall_Cycles <= 32'd0;
      Flush_Count  <= 32'd0;
    end else begin
      if (!PCWrite) Stall_Cycles <= Stall_Cycles + 32'd1;
      if (w_br_flush) Flush_Count <= Flush_Count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: two instances (LOAD_LATENCY 1 and 3) share stimulus.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] rs1, rs2, rd;
  logic       use2, memrd, br, req, rdy;

  logic a_pcw, a_ifw, a_iff, a_idf, a_pf, a_me;
  logic b_pcw, b_ifw, b_iff, b_idf, b_pf, b_me;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_sc, a_fc, b_sc, b_fc;
`endif

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_LATENCY(1), .MEM_TIMEOUT(8), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .IFID_RS1(rs1), .IFID_RS2(rs2), .IFID_UseRS2(use2),
    .IDEXE_RD(rd), .IDEXE_MemRead(memrd), .Branch_Taken(br), .DMem_Req(req), .DMem_Ready(rdy),
    .PCWrite(a_pcw), .IFID_Write(a_ifw), .IFID_Flush(a_iff), .IDEXE_Flush(a_idf),
    .Pipe_Freeze(a_pf), .Mem_Err(a_me)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Cycles(a_sc), .Flush_Count(a_fc)
`endif
  );

  hazard_controller #(.LOAD_LATENCY(3), .MEM_TIMEOUT(8), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .IFID_RS1(rs1), .IFID_RS2(rs2), .IFID_UseRS2(use2),
    .IDEXE_RD(rd), .IDEXE_MemRead(memrd), .Branch_Taken(br), .DMem_Req(req), .DMem_Ready(rdy),
    .PCWrite(b_pcw), .IFID_Write(b_ifw), .IFID_Flush(b_iff), .IDEXE_Flush(b_idf),
    .Pipe_Freeze(b_pf), .Mem_Err(b_me)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Cycles(b_sc), .Flush_Count(b_fc)
`endif
  );

  // Output vector order: {PCWrite, IFID_Write, IFID_Flush, IDEXE_Flush, Pipe_Freeze, Mem_Err}
  localparam logic [5:0] DEF = 6'b110000;
  localparam logic [5:0] STL = 6'b000100;
  localparam logic [5:0] BRF = 6'b111100;
  localparam logic [5:0] FRZ = 6'b000010;
  localparam logic [5:0] RST = 6'b001100;
  localparam logic [5:0] ERR = 6'b000001;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    exp_t e;
    logic [5:0] ga, gb;
    if (q.size() != 0) begin
      e  = q.pop_front();
      ga = {a_pcw, a_ifw, a_iff, a_idf, a_pf, a_me};
      gb = {b_pcw, b_ifw, b_iff, b_idf, b_pf, b_me};
      checks++;
      if (ga !== e.a) begin
        errors++;
        $display("FAIL %s [LL1] got=%b expected=%b", e.name, ga, e.a);
      end
      checks++;
      if (gb !== e.b) begin
        errors++;
        $display("FAIL %s [LL3] got=%b expected=%b", e.name, gb, e.b);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic [4:0] s1, input logic [4:0] s2,
                      input logic u2, input logic [4:0] d, input logic mr, input logic b,
                      input logic rq, input logic ry, input logic [5:0] ea, input logic [5:0] eb);
    exp_t e;
    rst_i = r; rs1 = s1; rs2 = s2; use2 = u2; rd = d; memrd = mr; br = b; req = rq; rdy = ry;
    e.a = ea; e.b = eb; e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; rs1 = '0; rs2 = '0; use2 = 1'b0; rd = '0;
    memrd = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
    @(posedge clk);
    #1;
    //     name        rst rs1 rs2 u2 rd mr br rq ry  LL1  LL3
    step("reset0",     0,  0,  0, 0, 0, 0, 0, 0, 0, RST, RST);
    step("reset1",     0,  5,  0, 0, 5, 1, 1, 1, 0, RST, RST);
    step("idle",       1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, DEF);
    // single load-use pulse
    step("lu_hit",     1,  5,  0, 0, 5, 1, 0, 0, 0, STL, STL);
    step("lu_s2",      1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, STL);
    step("lu_s3",      1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, STL);
    step("lu_done",    1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, DEF);
    step("rd_zero",    1,  0,  0, 0, 0, 1, 0, 0, 0, DEF, DEF);
    step("rs2_unused", 1,  1,  7, 0, 7, 1, 0, 0, 0, DEF, DEF);
    step("rs2_hit",    1,  1,  7, 1, 7, 1, 0, 0, 0, STL, STL);
    // branch aborts the stall in its second cycle
    step("br_in_stl",  1,  0,  0, 0, 0, 0, 1, 0, 0, BRF, BRF);
    step("br_after",   1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, DEF);
    // memory wait entered from LOAD_STALL on LL3 and from RUN on LL1
    step("mw_pre",     1,  5,  0, 0, 5, 1, 0, 0, 0, STL, STL);
    step("mw_f1",      1,  0,  0, 0, 0, 0, 0, 1, 0, FRZ, FRZ);
    step("mw_f2",      1,  0,  0, 0, 0, 0, 0, 1, 0, FRZ, FRZ);
    step("mw_f3",      1,  0,  0, 0, 0, 0, 1, 1, 0, FRZ, FRZ);
    step("mw_f4",      1,  5,  0, 0, 5, 1, 0, 1, 0, FRZ, FRZ);
    step("mw_f5rdy",   1,  0,  0, 0, 0, 0, 0, 1, 1, FRZ, FRZ);
    step("mw_res1",    1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, STL);
    step("mw_res2",    1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, STL);
    step("mw_res3",    1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, DEF);
    // timeout watchdog: entry cycle then 8 MEM_WAIT cycles
    step("to_entry",   1,  0,  0, 0, 0, 0, 0, 1, 0, FRZ, FRZ);
    for (int i = 1; i <= 8; i++)
      step($sformatf("to_wait%0d", i), 1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, FRZ);
    step("to_err",     1,  0,  0, 0, 0, 0, 0, 0, 0, DEF | ERR, DEF | ERR);
    step("to_sticky",  1,  0,  0, 0, 0, 0, 1, 0, 0, BRF | ERR, BRF | ERR);
    step("to_sticky2", 1,  0,  0, 0, 0, 0, 0, 0, 0, DEF | ERR, DEF | ERR);
    step("to_rst",     0,  0,  0, 0, 0, 0, 0, 0, 0, RST, RST);
    step("to_clear",   1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, DEF);
    // memwait + branch + hazard together: freeze wins
    step("all3",       1,  5,  0, 0, 5, 1, 1, 1, 0, FRZ, FRZ);
    step("all3_rdy",   1,  0,  0, 0, 0, 0, 0, 1, 1, FRZ, FRZ);
    step("all3_br",    1,  0,  0, 0, 0, 0, 1, 0, 0, BRF, BRF);
    step("all3_done",  1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, DEF);
    // reset mid-stall and mid-wait
    step("rs_stl",     1,  5,  0, 0, 5, 1, 0, 0, 0, STL, STL);
    step("rs_stl_rst", 0,  0,  0, 0, 0, 0, 0, 0, 0, RST, RST);
    step("rs_stl_run", 1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, DEF);
    step("rs_mw",      1,  0,  0, 0, 0, 0, 0, 1, 0, FRZ, FRZ);
    step("rs_mw_rst",  0,  0,  0, 0, 0, 0, 0, 1, 0, RST, RST);
    step("rs_mw_run",  1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, DEF);
    // back-to-back load-use hazards
    step("b2b_1",      1,  5,  0, 0, 5, 1, 0, 0, 0, STL, STL);
    step("b2b_2",      1,  6,  0, 0, 6, 1, 0, 0, 0, STL, STL);
    step("b2b_3",      1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, STL);
    step("b2b_4",      1,  0,  0, 0, 0, 0, 0, 0, 0, DEF, DEF);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
